intersection_ctrl: RTL
======================

INTERSECTION_CTRL -- requirements
Module: intersection_ctrl

Interface
REQ-001 Parameter NS_MIN_GREEN, default 8, minimum main-road (NS) green dwell in clk cycles.
REQ-002 Parameter EW_GREEN, default 5, fixed side-road (EW) green dwell in cycles.
REQ-003 Parameter YELLOW, default 2, yellow dwell in cycles for either road.
REQ-004 Parameter ALL_RED, default 1, all-red clearance dwell in cycles.
REQ-005 Port clk  input  1  single system clock; all state updates on its rising edge.
REQ-006 Port reset  input  1  asynchronous, active-high reset.
REQ-007 Port ew_req  input  1  side-road vehicle sensor, level, synchronous to clk.
REQ-008 Port ped_req  input  1  pedestrian button, one or more cycles high, synchronous to clk.
REQ-009 Ports ns_red, ns_yellow, ns_green  output  1 each  main-road lamps.
REQ-010 Ports ew_red, ew_yellow, ew_green  output  1 each  side-road lamps.
REQ-011 Port walk  output  1  pedestrian crossing signal for crossing the main road.

Function
REQ-012 FSM states: NS_G, NS_Y, AR_A, EW_G, EW_Y, AR_B; 4-bit dwell counter; every parameter SHALL be 1..15.
REQ-013 Counter SHALL be 0 on the first cycle of each state and increment by 1 per cycle; in NS_G it SHALL saturate at NS_MIN_GREEN-1, never wrap.
REQ-014 A state with dwell N SHALL occupy exactly N cycles: it exits when counter==N-1 (and the NS_G condition holds).
REQ-015 Transitions: NS_Y->AR_A, AR_A->EW_G, EW_G->EW_Y, EW_Y->AR_B, AR_B->NS_G, all unconditional at dwell end.
REQ-016 NS_G->NS_Y only when counter==NS_MIN_GREEN-1 and (ew_req==1 or ped_pend==1) in that cycle; otherwise NS_G holds indefinitely.
REQ-017 A request arriving after min green elapses SHALL move NS_G->NS_Y on the next clock edge (1-cycle latency).
REQ-018 Lamps SHALL be Moore outputs decoded from state: NS_G ns_green; NS_Y ns_yellow; EW_G ew_green; EW_Y ew_yellow; the other road red; AR_A/AR_B both red.
REQ-019 Exactly one lamp per road SHALL be on every cycle; ns_green/ns_yellow and ew_green/ew_yellow SHALL never overlap.
REQ-020 Unreachable state encodings SHALL go to AR_B on the next edge with all lamps red meanwhile.
REQ-021 EW_G SHALL last EW_GREEN cycles regardless of ew_req dropping mid-phase.

Reset
REQ-022 On reset assertion, state=AR_B, counter=0, ped_pend=0, walk_act=0 immediately, without waiting for clk.
REQ-023 During reset: ns_red=1, ew_red=1, all other lamps 0, walk=0.
REQ-024 After release, AR_B runs its full ALL_RED dwell, then NS_G; reset mid-phase SHALL abort the phase and discard pending requests.

Configuration
REQ-025 Macro PED_WALK_EN: when defined, ped_req sets register ped_pend (sticky until served); ped_pend counts as a request in REQ-016.
REQ-026 With PED_WALK_EN: on entry to EW_G, walk_act=1 if ped_pend or ped_req in that cycle, and ped_pend clears; walk=walk_act in EW_G only; walk_act clears on exit.
REQ-027 With PED_WALK_EN: ped_req during EW_G with walk_act=1 is absorbed; otherwise (incl. NS_Y, AR_A, EW_G with walk_act=0, EW_Y, AR_B) it sets ped_pend for the next cycle.
REQ-028 Without PED_WALK_EN: walk port present and tied 0, ped_req ignored, no ped_pend/walk_act storage.

Verification
REQ-029 Reset then idle inputs 50 cycles -> AR_B 1 cycle, then NS_G continuously, ew_red=1 throughout.
REQ-030 ew_req held 1 from reset release -> NS_G 8, NS_Y 2, AR_A 1, EW_G 5, EW_Y 2, AR_B 1, repeating (period 19).
REQ-031 ew_req pulse at NS_G cycle 20 -> NS_Y begins the next cycle; EW_G lasts exactly 5 cycles.
REQ-032 PED_WALK_EN, single 1-cycle ped_req at NS_G cycle 3, ew_req=0 -> NS_Y after counter 7; walk=1 for the 5 EW_G cycles only; ped_pend=0 after.
REQ-033 PED_WALK_EN, ped_req during EW_Y -> next NS_G ends at min green and a second walk phase follows.
REQ-034 Reset asserted mid EW_G -> lamps go ns_red/ew_red same cycle asynchronously; after release AR_B then NS_G, walk=0, no stale request served.

Source files
------------

// File: rtl/intersection_ctrl.sv
// Two-road intersection controller: demand-actuated main-road (NS) green with fixed side-road phase.
// Optional pedestrian walk phase on the side-road green is enabled by defining PED_WALK_EN.
module intersection_ctrl #(
    parameter int NS_MIN_GREEN = 8,
    parameter int EW_GREEN     = 5,
    parameter int YELLOW       = 2,
    parameter int ALL_RED      = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic ew_req,
    input  logic ped_req,
    output logic ns_red,
    output logic ns_yellow,
    output logic ns_green,
    output logic ew_red,
    output logic ew_yellow,
    output logic ew_green,
    output logic walk
);

    typedef enum logic [2:0] {
        NS_G = 3'd0,
        NS_Y = 3'd1,
        AR_A = 3'd2,
        EW_G = 3'd3,
        EW_Y = 3'd4,
        AR_B = 3'd5
    } state_t;

    // Last counter value of each dwell; a state exits when the counter reaches it.
    localparam logic [3:0] NS_LAST = 4'(NS_MIN_GREEN - 1);
    localparam logic [3:0] EW_LAST = 4'(EW_GREEN - 1);
    localparam logic [3:0] Y_LAST  = 4'(YELLOW - 1);
    localparam logic [3:0] AR_LAST = 4'(ALL_RED - 1);

    state_t     state_reg;
    state_t     state_next;
    logic [3:0] cnt_reg;
    logic [3:0] cnt_next;
    logic       ped_pend;

    // ------------------------------------------------------------------
    // Phase sequencing
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + 4'd1;
        case (state_reg)
            NS_G: begin
                if (cnt_reg >= NS_LAST) begin
                    if (ew_req || ped_pend) begin
                        state_next = NS_Y;
                        cnt_next   = 4'd0;
                    end else begin
                        cnt_next = NS_LAST;
                    end
                end
            end
            NS_Y: begin
                if (cnt_reg >= Y_LAST) begin
                    state_next = AR_A;
                    cnt_next   = 4'd0;
                end
            end
            AR_A: begin
                if (cnt_reg >= AR_LAST) begin
                    state_next = EW_G;
                    cnt_next   = 4'd0;
                end
            end
            EW_G: begin
                if (cnt_reg >= EW_LAST) begin
                    state_next = EW_Y;
                    cnt_next   = 4'd0;
                end
            end
            EW_Y: begin
                if (cnt_reg >= Y_LAST) begin
                    state_next = AR_B;
                    cnt_next   = 4'd0;
                end
            end
            AR_B: begin
                if (cnt_reg >= AR_LAST) begin
                    state_next = NS_G;
                    cnt_next   = 4'd0;
                end
            end
            default: begin
                state_next = AR_B;
                cnt_next   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= AR_B;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Lamp decode; any unknown encoding shows red on both roads.
    // ------------------------------------------------------------------
    always_comb begin
        ns_red    = 1'b0;
        ns_yellow = 1'b0;
        ns_green  = 1'b0;
        ew_red    = 1'b0;
        ew_yellow = 1'b0;
        ew_green  = 1'b0;
        case (state_reg)
            NS_G: begin
                ns_green = 1'b1;
                ew_red   = 1'b1;
            end
            NS_Y: begin
                ns_yellow = 1'b1;
                ew_red    = 1'b1;
            end
            EW_G: begin
                ns_red   = 1'b1;
                ew_green = 1'b1;
            end
            EW_Y: begin
                ns_red    = 1'b1;
                ew_yellow = 1'b1;
            end
            default: begin
                ns_red = 1'b1;
                ew_red = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pedestrian request latch and walk phase
    // ------------------------------------------------------------------
`ifdef PED_WALK_EN
    logic ped_pend_reg;
    logic ped_pend_next;
    logic walk_act_reg;
    logic walk_act_next;
    logic entering_ew;
    logic staying_ew;

    assign entering_ew = (state_reg == AR_A) && (state_next == EW_G);
    assign staying_ew  = (state_reg == EW_G) && (state_next == EW_G);

    always_comb begin
        ped_pend_next = ped_pend_reg;
        walk_act_next = 1'b0;
        if (entering_ew) begin
            // The pending request (or one arriving right now) is served by this phase.
            walk_act_next = ped_pend_reg || ped_req;
            ped_pend_next = 1'b0;
        end else begin
            if (staying_ew) begin
                walk_act_next = walk_act_reg;
            end
            // A press during an active walk is already being served.
            if (ped_req && !((state_reg == EW_G) && walk_act_reg)) begin
                ped_pend_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ped_pend_reg <= 1'b0;
            walk_act_reg <= 1'b0;
        end else begin
            ped_pend_reg <= ped_pend_next;
            walk_act_reg <= walk_act_next;
        end
    end

    assign ped_pend = ped_pend_reg;
    assign walk     = walk_act_reg && (state_reg == EW_G);
`else
    // Without the walk feature the button has no effect on sequencing.
    logic unused_ped_req;

    assign unused_ped_req = ped_req;
    assign ped_pend       = 1'b0;
    assign walk           = 1'b0;
`endif

endmodule
